and8_operand_collector: RTL and testbench
=========================================

Name: and8_operand_collector

Overview:
- Upstream feeder for the 8-operand reduction-AND stage.
- Accepts a stream of WIDTH-bit words over a valid/ready handshake and packs them into eight operand registers a..h, which drive the reduction stage's inputs directly.
- Presents the full set with out_valid and holds it stable until the consumer accepts it.
- A short group, terminated by in_last, is padded with all-ones so it passes through the downstream AND unchanged.

Parameters:
- WIDTH, 8, width of each operand word and of in_data.
- NUM_OPS, 8, operands per group. Fixed at 8 to match ports a..h; any other value is unsupported.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  incoming operand word.
- in_valid  input  1  in_data is valid this cycle.
- in_last  input  1  qualifies in_data as the final word of the group; valid only with in_valid.
- in_ready  output  1  collector accepts a word this cycle.
- flush  input  1  synchronous discard of the partial group.
- a, b, c, d, e, f, g, h  output  WIDTH each  registered operands; slot 0 is a, slot 7 is h.
- out_valid  output  1  a..h hold a complete group.
- out_ready  input  1  downstream accepts the group.
- fill_count  output  4  words captured in the current group, 0..8.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State = FILL, slot index = 0.
  - a..h = 0, out_valid = 0, fill_count = 0.
  - in_ready is combinational and therefore 1 immediately after reset.
- States: FILL and FULL.
- Accept definitions:
  - Input accept = in_valid && in_ready.
  - Output accept = out_valid && out_ready.
- FILL:
  - in_ready = 1, out_valid = 0.
  - On input accept, in_data is written to slot[idx], idx increments and fill_count increments.
  - If idx == 7, or in_last = 1: every slot above idx is loaded with all-ones in the same edge, state goes to FULL, and out_valid = 1 from the next cycle.
  - Latency: the last word is captured at edge N; out_valid is high from edge N onward.
- FULL:
  - out_valid = 1, and a..h are stable while out_valid && !out_ready.
  - in_ready = out_ready, so a word can be accepted in the same cycle the group drains.
  - Output accept with no input accept: go to FILL, idx = 0, fill_count = 0.
  - Output accept with input accept (simultaneous drain/refill): the word goes into slot a, idx = 1, fill_count = 1, state goes to FILL.
    - If that word also carries in_last: slots b..h = all-ones and the state stays FULL.
  - Slots not yet rewritten keep their old values until overwritten. Downstream must only sample when out_valid = 1.
- fill_count reads 8 while FULL after a full group. After a short group it reads the number of real words (1..7); it does not count padding.
- flush:
  - In FILL: idx = 0, fill_count = 0, no state change. A word presented in the same cycle is dropped and in_ready stays 1.
  - In FULL: ignored; a presented group is never destroyed.
- in_last with in_valid = 0 is ignored.
- Slot-index wrap is impossible because idx 7 always transitions to FULL.
- Reset asserted mid-group or mid-hold aborts immediately to the reset values; no partial group survives.
- No combinational path from in_data to a..h. The only combinational output is in_ready, which depends on state and out_ready.

Decomposition:
- Shared package holds:
  - state encoding constants FILL = 1'b0, FULL = 1'b1;
  - NUM_OPS = 8;
  - IDX_W = 3;
  - the padding value {WIDTH{1'b1}}.
- One natural sub-module, and8_slot_reg: a per-operand register with write-enable, pad-enable and async active-low clear. It is instantiated eight times.
- FSM, index counter and handshake logic stay in the top.

Test Plan:
- Eight back-to-back words 0x01..0x08 with in_valid = 1 and out_ready = 0:
  - a..h = 0x01..0x08, out_valid = 1 after the 8th edge, fill_count = 8, in_ready = 0.
  - Group held unchanged for 5 cycles; raising out_ready drains it in one cycle.
- Short group 0x7F, 0x3C with in_last on the second word (WIDTH = 8):
  - a = 0x7F, b = 0x3C, c..h = 0xFF, fill_count = 2, out_valid = 1.
  - Downstream AND result equals the AND of a and b only.
- Simultaneous drain and refill: in FULL, out_ready = 1 and in_valid = 1 with in_data = 0xAA in the same cycle:
  - Next cycle a = 0xAA, fill_count = 1, state FILL, out_valid = 0.
- Flush after 3 words, then 8 words 0x10..0x17:
  - After the flush fill_count = 0.
  - Final a..h = 0x10..0x17; no stale data from before the flush.
- rst_n pulsed low asynchronously (between clock edges) while FULL:
  - out_valid, a..h and fill_count are 0 before the next clock edge.
  - in_ready = 1 after release.
- flush asserted while FULL with out_ready = 0:
  - Group and out_valid unchanged.

Source files
------------

// File: rtl/and8_operand_collector_pkg.sv
// Shared definitions for the 8-operand AND collector: state encoding,
// operand count, slot index width and the padding bit.
package and8_operand_collector_pkg;

  typedef enum logic {
    StFill = 1'b0,
    StFull = 1'b1
  } state_e;

  localparam int unsigned NUM_OPS = 8;
  localparam int unsigned IDX_W   = 3;

  // Padding is all-ones so unused slots are transparent to the downstream AND.
  localparam logic PAD_BIT = 1'b1;

endpackage

// File: rtl/and8_operand_collector_if.sv
// Handshake and operand bus between the word source, the collector and the
// reduction-AND stage.
interface and8_operand_collector_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             flush;
  logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       fill_count;

  modport master (
    output in_data, in_valid, in_last, flush, out_ready,
    input  in_ready, a, b, c, d, e, f, g, h, out_valid, fill_count
  );

  modport slave (
    input  in_data, in_valid, in_last, flush, out_ready,
    output in_ready, a, b, c, d, e, f, g, h, out_valid, fill_count
  );

endinterface

// File: rtl/and8_slot_reg.sv
// One operand register: load a word, load the padding value, or hold.
// A word write takes priority over padding.
module and8_slot_reg
  import and8_operand_collector_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic             pad_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (wr_en_i) begin
      q_q <= wdata_i;
    end else if (pad_en_i) begin
      q_q <= {WIDTH{PAD_BIT}};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/and8_operand_collector.sv
// Packs a stream of words into eight operand registers for the reduction-AND
// stage, padding short groups with all-ones and holding the group until taken.
module and8_operand_collector
  import and8_operand_collector_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  and8_operand_collector_if.slave bus
);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       cnt_q;
  logic [IDX_W-1:0] wr_idx;
  logic             in_acc;
  logic             out_acc;
  logic             wr_acc;
  logic             done;
  logic [NUM_OPS-1:0] wr_en;
  logic [NUM_OPS-1:0] pad_en;
  logic [WIDTH-1:0]   slot_q [NUM_OPS];

  assign bus.in_ready  = (state_q == StFill) ? 1'b1 : bus.out_ready;
  assign bus.out_valid = (state_q == StFull);

  assign in_acc  = bus.in_valid && bus.in_ready;
  assign out_acc = bus.out_valid && bus.out_ready;
  // A flush while filling swallows any word offered in the same cycle.
  assign wr_acc  = in_acc && !((state_q == StFill) && bus.flush);
  // During a drain/refill cycle the new word always starts a fresh group.
  assign wr_idx  = (state_q == StFull) ? '0 : idx_q;
  assign done    = wr_acc && (bus.in_last || (wr_idx == IDX_W'(NUM_OPS - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (bus.flush) begin
            idx_q <= '0;
            cnt_q <= '0;
          end else if (wr_acc) begin
            idx_q <= idx_q + 1'b1;
            cnt_q <= cnt_q + 1'b1;
            if (done) state_q <= StFull;
          end
        end
        StFull: begin
          if (out_acc) begin
            if (wr_acc) begin
              idx_q   <= IDX_W'(1);
              cnt_q   <= 4'd1;
              state_q <= done ? StFull : StFill;
            end else begin
              idx_q   <= '0;
              cnt_q   <= '0;
              state_q <= StFill;
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_slot
    assign wr_en[i]  = wr_acc && (wr_idx == IDX_W'(i));
    assign pad_en[i] = done && (IDX_W'(i) > wr_idx);

    and8_slot_reg #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en_i (wr_en[i]),
      .pad_en_i(pad_en[i]),
      .wdata_i (bus.in_data),
      .q_o     (slot_q[i])
    );
  end

  assign bus.a = slot_q[0];
  assign bus.b = slot_q[1];
  assign bus.c = slot_q[2];
  assign bus.d = slot_q[3];
  assign bus.e = slot_q[4];
  assign bus.f = slot_q[5];
  assign bus.g = slot_q[6];
  assign bus.h = slot_q[7];

  assign bus.fill_count = cnt_q;

endmodule

// File: tb/tb_and8_operand_collector.sv
// Directed and random stimulus for the operand collector, checked against a
// word-level group model kept in the bench.
module tb_and8_operand_collector;

  logic clk;
  logic rst_n;

  and8_operand_collector_if #(.WIDTH(8)) bus ();

  and8_operand_collector #(
    .WIDTH(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a group is "presented" or not, with a count of real words so far.
  bit         m_full;
  int         m_cnt;
  logic [7:0] m_slot [8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_cnt  = 0;
    for (int k = 0; k < 8; k++) m_slot[k] = 8'h00;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".slots"}, {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h},
        {m_slot[0], m_slot[1], m_slot[2], m_slot[3],
         m_slot[4], m_slot[5], m_slot[6], m_slot[7]});
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_full));
    chk({tag, ".fill_count"}, 64'(bus.fill_count), 64'(m_cnt));
  endtask

  // One clock: drive inputs, check in_ready mid-cycle, then advance the model.
  task automatic step(input logic v, input logic [7:0] dat, input logic l,
                      input logic fl, input logic ordy);
    bit rdy;
    bit acc_in;
    bit acc_out;
    bus.in_valid  = v;
    bus.in_data   = dat;
    bus.in_last   = l;
    bus.flush     = fl;
    bus.out_ready = ordy;
    @(negedge clk);
    rdy = !m_full || ordy;
    chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    @(posedge clk);
    acc_in  = v && rdy;
    acc_out = m_full && ordy;
    if (!m_full) begin
      if (fl) begin
        m_cnt = 0;
      end else if (acc_in) begin
        m_slot[m_cnt] = dat;
        m_cnt++;
        if (m_cnt == 8 || l) begin
          for (int k = m_cnt; k < 8; k++) m_slot[k] = 8'hFF;
          m_full = 1'b1;
        end
      end
    end else if (acc_out) begin
      if (acc_in) begin
        m_slot[0] = dat;
        m_cnt     = 1;
        m_full    = l;
        if (l) for (int k = 1; k < 8; k++) m_slot[k] = 8'hFF;
      end else begin
        m_full = 1'b0;
        m_cnt  = 0;
      end
    end
    #1;
    chk_outputs("step");
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset");
    chk("reset.in_ready", 64'(bus.in_ready), 64'(1));
    rst_n = 1'b1;

    // Full group with the consumer stalled, held, then drained.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b0);
    chk("full.a_to_h", {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h},
        64'h0102030405060708);
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Short group padded with all-ones.
    step(1'b1, 8'h7F, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    chk("short.and_result",
        64'(bus.a & bus.b & bus.c & bus.d & bus.e & bus.f & bus.g & bus.h), 64'h3C);

    // Drain and refill in the same cycle.
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    chk("refill.a", 64'(bus.a), 64'hAA);

    // Flush a partial group, with a word dropped on the flush cycle.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    chk("flush.a_to_h", {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h},
        64'h1011121314151617);

    // Flush while a group is presented is ignored.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset between clock edges while the group is held.
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_outputs("async_reset");
    #2;
    rst_n = 1'b1;
    #1;
    chk("async_reset.in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Random traffic, including in_last without in_valid.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
